// File: rtl/load_store_unit.sv
// Load/store unit: one byte-addressed access per handshake against a word-addressed,
// single-port data memory, with read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_size,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RMW_READ = 3'd2,
        S_STORE    = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    // Upper address bits wrap modulo memory size and are deliberately dropped.
    logic addr_unused_s;
    assign addr_unused_s = ^req_addr[31:ADDR_WIDTH+2];

    function automatic logic req_bad(input logic we, input logic [2:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            3'b000:  bad = 1'b0;
            3'b001:  bad = off[0];
            3'b010:  bad = (off != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract_load(input logic [DATA_WIDTH-1:0] word,
                                                            input logic [2:0] size,
                                                            input logic [1:0] off);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_store(input logic [DATA_WIDTH-1:0] word,
                                                           input logic [DATA_WIDTH-1:0] wdata,
                                                           input logic [2:0] size,
                                                           input logic [1:0] off);
        logic [DATA_WIDTH-1:0] r;
        r = word;
        case (size)
            3'b000: r[{off, 3'b000} +: 8] = wdata[7:0];
            3'b001: begin
                if (off[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Next-state and next-output computation; all outputs are registered.
    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        off_d         = off_q;
        wdata_d       = wdata_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_we_d      = mem_we_q;
        mem_re_d      = mem_re_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d      = req_size;
                    off_d       = req_addr[1:0];
                    wdata_d     = req_wdata;
                    mem_addr_d  = req_addr[ADDR_WIDTH+1:2];
                    req_ready_d = 1'b0;
                    if (req_bad(req_we, req_size, req_addr[1:0])) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                    end else if (!req_we) begin
                        state_d  = S_LOAD;
                        mem_re_d = 1'b1;
                    end else if (req_size == 3'b010) begin
                        state_d       = S_STORE;
                        mem_we_d      = 1'b1;
                        mem_data_in_d = req_wdata;
                    end else begin
                        state_d  = S_RMW_READ;
                        mem_re_d = 1'b1;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_LOAD: begin
                mem_re_d     = 1'b0;
                resp_rdata_d = extract_load(mem_data_out, size_q, off_q);
                resp_err_d   = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RMW_READ: begin
                // Drop read before raising write so the two enables never overlap.
                mem_re_d      = 1'b0;
                mem_we_d      = 1'b1;
                mem_data_in_d = merge_store(mem_data_out, wdata_q, size_q, off_q);
                state_d       = S_STORE;
            end
            S_STORE: begin
                mem_we_d     = 1'b0;
                resp_rdata_d = 32'h0000_0000;
                resp_err_d   = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0000_0000;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d      = S_IDLE;
                mem_we_d     = 1'b0;
                mem_re_d     = 1'b0;
                resp_valid_d = 1'b0;
                resp_rdata_d = 32'h0000_0000;
                resp_err_d   = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            size_q        <= 3'b000;
            off_q         <= 2'b00;
            wdata_q       <= 32'h0000_0000;
            mem_addr_q    <= '0;
            mem_data_in_q <= 32'h0000_0000;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0000_0000;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            off_q         <= off_d;
            wdata_q       <= wdata_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 16-word behavioural memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_data_out;
    logic [31:0] mem [16];

    int total = 0;
    int bad = 0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_we(mem_we), .mem_re(mem_re), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h0BAD_F00D;
            mem[1] <= 32'h8899_AABB;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_data_in;
        end
    end
    assign mem_data_out = mem[mem_addr];

    // Issue one request and observe per-cycle enables until the response (bounded).
    task automatic run_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, output int resp_cyc,
                           output logic [7:0] we_mask, output logic [7:0] re_mask,
                           output logic [31:0] rdata, output logic err, output logic [3:0] addr_c1);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_size = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        resp_cyc = -1; we_mask = 8'h00; re_mask = 8'h00; rdata = 32'hX; err = 1'bx; addr_c1 = 4'hX;
        for (int c = 1; c < 8 && resp_cyc < 0; c++) begin
            @(negedge clk);
            we_mask[c] = mem_we;
            re_mask[c] = mem_re;
            if (c == 1) addr_c1 = mem_addr;
            if (resp_valid) begin
                resp_cyc = c; rdata = resp_rdata; err = resp_err;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", resp_err); end
        total++; if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL reset_mem_en got %b want 00", {mem_we, mem_re}); end
        total++; if (mem_addr !== 4'h0) begin bad++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        total++; if (mem_data_in !== 32'h0) begin bad++; $display("FAIL reset_mem_data_in got %h want 0", mem_data_in); end
    endtask

    task automatic test_load;
        logic [2:0]  sz [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ad [5] = '{32'h5, 32'h5, 32'h6, 32'h6, 32'h4};
        logic [31:0] ex [5] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_8899, 32'h8899_AABB};
        int rc; logic [7:0] wm, rm; logic [31:0] rd; logic er; logic [3:0] a1;
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, sz[i], ad[i], 32'h0, rc, wm, rm, rd, er, a1);
            total++; if (rc !== 2) begin bad++; $display("FAIL load%0d_latency got %0d want 2", i, rc); end
            total++; if (rd !== ex[i]) begin bad++; $display("FAIL load%0d_rdata got %h want %h", i, rd, ex[i]); end
            total++; if (er !== 1'b0) begin bad++; $display("FAIL load%0d_err got %b want 0", i, er); end
            total++; if ({wm, rm} !== {8'h00, 8'h02}) begin bad++; $display("FAIL load%0d_enables got we=%b re=%b want we=00000000 re=00000010", i, wm, rm); end
        end
    endtask

    task automatic test_store;
        int rc; logic [7:0] wm, rm; logic [31:0] rd; logic er; logic [3:0] a1;
        run_req(1'b1, 3'b000, 32'h7, 32'hFFFF_FF12, rc, wm, rm, rd, er, a1);
        @(posedge clk); #1;
        total++; if (rc !== 3) begin bad++; $display("FAIL sb_latency got %0d want 3", rc); end
        total++; if ({wm, rm} !== {8'h04, 8'h02}) begin bad++; $display("FAIL sb_enables got we=%b re=%b want we=00000100 re=00000010", wm, rm); end
        total++; if (mem[1] !== 32'h1299_AABB) begin bad++; $display("FAIL sb_word got %h want 1299aabb", mem[1]); end
        total++; if ({er, rd} !== {1'b0, 32'h0}) begin bad++; $display("FAIL sb_resp got err=%b rdata=%h want 0/0", er, rd); end
        run_req(1'b1, 3'b001, 32'h4, 32'h0000_5566, rc, wm, rm, rd, er, a1);
        @(posedge clk); #1;
        total++; if (rc !== 3) begin bad++; $display("FAIL sh_latency got %0d want 3", rc); end
        total++; if (mem[1] !== 32'h1299_5566) begin bad++; $display("FAIL sh_word got %h want 12995566", mem[1]); end
        run_req(1'b1, 3'b010, 32'h4, 32'hDEAD_BEEF, rc, wm, rm, rd, er, a1);
        @(posedge clk); #1;
        total++; if (rc !== 2) begin bad++; $display("FAIL sw_latency got %0d want 2", rc); end
        total++; if ({wm, rm} !== {8'h02, 8'h00}) begin bad++; $display("FAIL sw_enables got we=%b re=%b want we=00000010 re=00000000", wm, rm); end
        total++; if (mem[1] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_word got %h want deadbeef", mem[1]); end
    endtask

    task automatic test_errors;
        logic        ew [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  es [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] ea [4] = '{32'h6, 32'h3, 32'h4, 32'h0};
        int rc; logic [7:0] wm, rm; logic [31:0] rd; logic er; logic [3:0] a1;
        for (int i = 0; i < 4; i++) begin
            run_req(ew[i], es[i], ea[i], 32'h7777_7777, rc, wm, rm, rd, er, a1);
            total++; if (rc !== 1) begin bad++; $display("FAIL err%0d_latency got %0d want 1", i, rc); end
            total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL err%0d_resp got err=%b rdata=%h want 1/0", i, er, rd); end
            total++; if ({wm, rm} !== 16'h0) begin bad++; $display("FAIL err%0d_enables got we=%b re=%b want 0", i, wm, rm); end
        end
        @(posedge clk); #1;
        total++; if ({mem[0], mem[1]} !== {32'h0BAD_F00D, 32'hDEAD_BEEF}) begin bad++; $display("FAIL err_mem got %h %h want 0badf00d deadbeef", mem[0], mem[1]); end
    endtask

    task automatic test_wrap;
        int rc; logic [7:0] wm, rm; logic [31:0] rd; logic er; logic [3:0] a1;
        run_req(1'b0, 3'b010, 32'h44, 32'h0, rc, wm, rm, rd, er, a1);
        total++; if (a1 !== 4'h1) begin bad++; $display("FAIL wrap_mem_addr got %h want 1", a1); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wrap_rdata got %h want deadbeef", rd); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h4; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'h1111_1111;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            total++; if ({resp_valid, req_ready, mem_we} !== 3'b100) begin bad++; $display("FAIL hold%0d_flags got valid=%b ready=%b we=%b want 1/0/0", k, resp_valid, req_ready, mem_we); end
            total++; if (resp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hold%0d_rdata got %h want deadbeef", k, resp_rdata); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        total++; if ({req_ready, resp_valid} !== 2'b10) begin bad++; $display("FAIL release_flags got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
        total++; if (mem[0] !== 32'h0BAD_F00D) begin bad++; $display("FAIL release_mem0 got %h want 0badf00d", mem[0]); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL second_we got %b want 1", mem_we); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL second_resp got %b want 1", resp_valid); end
        total++; if (mem[0] !== 32'h1111_1111) begin bad++; $display("FAIL second_mem0 got %h want 11111111", mem[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'b000; req_addr = 32'h7; req_wdata = 32'h0000_00AB;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (mem_re !== 1'b1) begin bad++; $display("FAIL mid_rmw_read got re=%b want 1", mem_re); end
        #2 rst = 1'b1;
        #1;
        total++; if ({mem_we, mem_re, req_ready, resp_valid} !== 4'b0010) begin bad++; $display("FAIL mid_async got we=%b re=%b ready=%b valid=%b want 0/0/1/0", mem_we, mem_re, req_ready, resp_valid); end
        seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_we || resp_valid || !req_ready) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_after got activity=%b want 0", seen); end
        total++; if (mem[1] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mid_word got %h want deadbeef", mem[1]); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        preload = 1'b0;
        test_reset();
        test_load();
        test_store();
        test_errors();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
